adc_bcd_conv: RTL and testbench
===============================

ADC_BCD_CONV -- requirements
Module: adc_bcd_conv

Interface
REQ-001 Parameter: DW, 12, binary sample width; legal range 4..13, so that the maximum value of 8191 fits in four BCD digits.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: clr  input  1  reset; asynchronous, active-high.
REQ-004 Port: din  input  DW  unsigned binary sample from the ADC capture stage.
REQ-005 Port: din_valid  input  1  single-cycle strobe qualifying din.
REQ-006 Port: busy  output  1  high whenever the converter is not in IDLE.
REQ-007 Port: done  output  1  single-cycle pulse; the dig outputs took a new value this cycle.
REQ-008 Port: drop  output  1  single-cycle pulse; din_valid arrived while busy and was discarded.
REQ-009 Port: dig0..dig3  output  4 each  registered BCD digits (dig0 = units ... dig3 = thousands), feeding the 4-digit hex display driver directly.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, CONV, DONE.
REQ-011 IDLE with din_valid=1: capture din into a DW-bit shift register, clear the 16-bit BCD work register, clear the iteration counter, and go to CONV.
REQ-012 IDLE with din_valid=0: remain in IDLE; all outputs hold.
REQ-013 CONV, per cycle: each BCD nibble of the work register >=5 gets +3 (all nibbles evaluated in parallel on pre-shift values); then {bcd, bin} shifts left by 1; the counter increments.
REQ-014 CONV SHALL last exactly DW cycles; after the DW-th shift, the FSM goes to DONE.
REQ-015 DONE (1 cycle): copy the work register to dig3..dig0, assert done=1, and return to IDLE.
REQ-016 Latency: done SHALL assert exactly DW+1 cycles after the din_valid capture edge (13 cycles for DW=12).
REQ-017 dig0..dig3 SHALL change only in the DONE cycle and hold between conversions; no partial results are visible.
REQ-018 busy = (state != IDLE); busy SHALL be low in the cycle after DONE.
REQ-019 din_valid while busy=1 (including the DONE cycle): the sample is discarded, drop=1 for that cycle, and the conversion in progress is unaffected.
REQ-020 din SHALL be sampled only on the accepted capture edge; changes to din during CONV SHALL have no effect.
REQ-021 For every input 0..2^DW-1, each digit SHALL be a valid BCD value 0..9, and the digits SHALL equal the decimal value of din.
REQ-022 Back-to-back operation: a din_valid in the first IDLE cycle after DONE SHALL be accepted, giving a minimum sample spacing of DW+2 cycles.

Reset
REQ-023 clr=1 SHALL immediately force: state=IDLE, busy=0, done=0, drop=0, dig0..dig3=0, work/shift registers=0, counter=0.
REQ-024 clr asserted mid-CONV SHALL abort the conversion: no done pulse, and the digits read 0 after reset.
REQ-025 din_valid coincident with clr=1 SHALL be ignored.
REQ-026 After clr deasserts, the first accepted din_valid SHALL behave per REQ-011.

Verification
REQ-027 Reset, then din=0 with one din_valid -> done at +13 cycles; dig3..dig0 = 0,0,0,0.
REQ-028 din=12'd4095 -> after 13 cycles, dig3..dig0 = 4,0,9,5; done high for exactly 1 cycle; busy high for 13 cycles.
REQ-029 din=1234, then din=999 strobed 3 cycles later -> drop pulses once; result 1,2,3,4 only; no second done pulse.
REQ-030 din=1234, then din=999 strobed in the first IDLE cycle after done -> second done 14 cycles after the first; digits read 0,9,9,9.
REQ-031 clr pulsed at cycle 6 of a conversion of 3000 -> busy=0 and dig=0 immediately; no done pulse; the next conversion of 7 gives 0,0,0,7.
REQ-032 Exhaustive sweep 0..4095 with a scoreboard -> every result matches the decimal value and every digit is <=9.

Source files
------------

// File: rtl/adc_bcd_conv.sv
// adc_bcd_conv: converts a DW-bit unsigned ADC sample into four BCD digits
// using the shift-and-add-3 (double dabble) method. Each accepted sample takes
// DW shift cycles plus one DONE cycle. The digits update together and then
// hold until the next conversion finishes.
module adc_bcd_conv #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          busy,
    output logic          done,
    output logic          drop,
    output logic [3:0]    dig0,
    output logic [3:0]    dig1,
    output logic [3:0]    dig2,
    output logic [3:0]    dig3
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DW-1:0]     r_bin;
    logic [15:0]       r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [15:0]       r_dig;
    logic              r_done;
    logic [15:0]       w_adj;
    logic [DW+15:0]    w_shift;
    logic              w_last;

    // The DW-th shift is the one taken when the counter holds DW-1
    assign w_last  = (r_cnt == CW'(DW - 1));
    assign w_shift = {w_adj[14:0], r_bin, 1'b0};

    // Add 3 to every BCD nibble that is 5 or more, all from pre-shift values
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < 4; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: accept in IDLE, shift DW times, then one DONE cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (din_valid) w_next = CONV;
            CONV:    if (w_last)    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture, shift-and-adjust, and publish digits at the end of DONE
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_dig  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_bin <= din;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                CONV: begin
                    {r_bcd, r_bin} <= w_shift;
                    r_cnt          <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_dig <= r_bcd;
                end
                default: begin
                    r_bin <= '0;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign drop = din_valid && (r_state != IDLE);
    assign dig0 = r_dig[3:0];
    assign dig1 = r_dig[7:4];
    assign dig2 = r_dig[11:8];
    assign dig3 = r_dig[15:12];

endmodule

// File: tb/tb_adc_bcd_conv.sv
// tb_adc_bcd_conv: self-checking bench for adc_bcd_conv. Expected digits come
// from plain decimal arithmetic on the sample value.
module tb_adc_bcd_conv;

    localparam int DW = 12;

    logic          clk;
    logic          clr;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          busy;
    logic          done;
    logic          drop;
    logic [3:0]    dig0;
    logic [3:0]    dig1;
    logic [3:0]    dig2;
    logic [3:0]    dig3;
    logic [15:0]   digits;

    int checks = 0;
    int errors = 0;

    adc_bcd_conv #(.DW(DW)) dut (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_valid (din_valid),
        .busy      (busy),
        .done      (done),
        .drop      (drop),
        .dig0      (dig0),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3)
    );

    assign digits = {dig3, dig2, dig1, dig0};

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: decimal digits of v, thousands in the top nibble
    function automatic logic [15:0] toBcd(input int v);
        toBcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Strobes one sample (caller is mid-cycle in IDLE) and waits for done.
    // Returns to the caller in the done cycle so a follow-up strobe is back-to-back.
    task automatic runConversion(input int value, output int latency, output logic [15:0] result);
        din       = DW'(value);
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = DW'($urandom);
        latency   = 0;
        result    = 16'hxxxx;
        while (latency < 40) begin
            @(posedge clk); #1;
            latency++;
            din = DW'($urandom);
            if (done) begin
                result = digits;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr       = 1'b1;
        din       = 12'd1234;
        din_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, drop} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags got busy/done/drop=%b want 000", {busy, done, drop});
        end
        checks++;
        if (digits !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_digits got %h want 0000", digits);
        end
        clr       = 1'b0;
        din_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid_ignored got busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero_and_max();
        int          lat;
        logic [15:0] res;
        int          busyCycles;
        int          doneCycles;
        int          doneAt;
        runConversion(0, lat, res);
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("[TB] FAIL zero_latency got %0d want 13", lat);
        end
        checks++;
        if (res !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL zero_digits got %h want 0000", res);
        end
        din        = 12'd4095;
        din_valid  = 1'b1;
        @(posedge clk); #1;
        din_valid  = 1'b0;
        busyCycles = busy ? 1 : 0;
        doneCycles = 0;
        doneAt     = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            din = DW'($urandom);
            if (busy) busyCycles++;
            if (done) begin
                doneCycles++;
                if (doneAt == 0) doneAt = n;
            end
            if (n < 13 && digits !== 16'h0000) begin
                checks++;
                errors++;
                $display("[TB] FAIL max_hold cycle %0d got %h want 0000", n, digits);
            end
        end
        checks++;
        if (busyCycles !== 13) begin
            errors++;
            $display("[TB] FAIL max_busy_cycles got %0d want 13", busyCycles);
        end
        checks++;
        if (doneCycles !== 1 || doneAt !== 13) begin
            errors++;
            $display("[TB] FAIL max_done got count=%0d at=%0d want count=1 at=13", doneCycles, doneAt);
        end
        checks++;
        if (digits !== toBcd(4095)) begin
            errors++;
            $display("[TB] FAIL max_digits got %h want %h", digits, toBcd(4095));
        end
    endtask

    task automatic test_drop();
        int          drops = 0;
        int          dones = 0;
        int          doneAt = 0;
        logic [15:0] res = 16'hxxxx;
        din       = 12'd1234;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            din_valid = (n == 3);
            din       = 12'd999;
            #1;
            if (drop) drops++;
            if (done) begin
                dones++;
                if (doneAt == 0) begin
                    doneAt = n;
                    res    = digits;
                end
            end
        end
        din_valid = 1'b0;
        checks++;
        if (drops !== 1) begin
            errors++;
            $display("[TB] FAIL drop_count got %0d want 1", drops);
        end
        checks++;
        if (dones !== 1 || doneAt !== 13) begin
            errors++;
            $display("[TB] FAIL drop_done got count=%0d at=%0d want count=1 at=13", dones, doneAt);
        end
        checks++;
        if (res !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL drop_digits got %h want 1234", res);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          gap;
        logic [15:0] res;
        runConversion(1234, lat, res);
        checks++;
        if (lat !== 13 || res !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL b2b_first got lat=%0d dig=%h want lat=13 dig=1234", lat, res);
        end
        din       = 12'd999;
        din_valid = 1'b1;
        #1;
        checks++;
        if (drop !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_no_drop got %b want 0", drop);
        end
        gap = 0;
        while (gap < 40) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
            gap++;
            if (done) break;
        end
        checks++;
        if (gap !== 14) begin
            errors++;
            $display("[TB] FAIL b2b_spacing got %0d want 14", gap);
        end
        checks++;
        if (digits !== 16'h0999) begin
            errors++;
            $display("[TB] FAIL b2b_digits got %h want 0999", digits);
        end
    endtask

    task automatic test_abort();
        int          dones = 0;
        int          lat;
        logic [15:0] res;
        din       = 12'd3000;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({busy, done, drop} !== 3'b000 || digits !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL abort_immediate got busy/done/drop=%b dig=%h want 000 0000", {busy, done, drop}, digits);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done got %0d want 0", dones);
        end
        runConversion(7, lat, res);
        checks++;
        if (lat !== 13 || res !== 16'h0007) begin
            errors++;
            $display("[TB] FAIL abort_next got lat=%0d dig=%h want lat=13 dig=0007", lat, res);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int          value  = int'($urandom_range(0, 4095));
            int          offset = int'($urandom_range(1, 12));
            int          drops  = 0;
            int          dones  = 0;
            int          doneAt = 0;
            logic [15:0] res    = 16'hxxxx;
            din       = DW'(value);
            din_valid = 1'b1;
            @(posedge clk); #1;
            din_valid = 1'b0;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk); #1;
                din_valid = (n == offset);
                din       = DW'($urandom);
                #1;
                if (drop) drops++;
                if (done) begin
                    dones++;
                    if (doneAt == 0) begin
                        doneAt = n;
                        res    = digits;
                    end
                end
            end
            din_valid = 1'b0;
            checks++;
            if (drops !== 1 || dones !== 1 || doneAt !== 13 || res !== toBcd(value)) begin
                errors++;
                $display("[TB] FAIL random v=%0d off=%0d got drops=%0d dones=%0d at=%0d dig=%h want 1 1 13 %h",
                         value, offset, drops, dones, doneAt, res, toBcd(value));
            end
        end
    endtask

    task automatic test_sweep();
        int          lat;
        logic [15:0] res;
        logic        validBcd;
        for (int v = 0; v < (1 << DW); v++) begin
            runConversion(v, lat, res);
            validBcd = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (res[4*k +: 4] > 4'd9) validBcd = 1'b0;
            end
            checks++;
            if (lat !== 13 || res !== toBcd(v) || validBcd !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sweep v=%0d got lat=%0d dig=%h want lat=13 dig=%h", v, lat, res, toBcd(v));
            end
        end
    endtask

    // Runs every scenario in order and prints the summary
    initial begin
        clr       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        test_reset();
        test_zero_and_max();
        test_drop();
        test_back_to_back();
        test_abort();
        test_random();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
